// File: rtl/vco_freq_counter.sv
// Counts rising edges of an asynchronous oscillator output over a 2^g clk-cycle gate window.
// Owns the oscillator reset line and exposes the saturating result a byte at a time.
`timescale 1ns/1ps
module vco_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vco_in,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic [3:0]       i_gate_log2,
  input  logic             i_rd_sel,
  output logic             o_vco_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic [7:0]       o_byte_out
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [3:0]             r_gate;
  logic [SW-1:0]          r_settle;
  logic [14:0]            r_win;
  logic [CNT_W-1:0]       r_acc;
  logic                   r_pend;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic                   r_vco_rst;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_edge;
  logic [14:0]            w_win_max;
  logic                   w_win_last;
  logic [CNT_W-1:0]       w_acc_next;
  logic                   w_pend_next;
  logic [15:0]            w_cnt16;

  // The synchronizer free-runs in every state so entering MEASURE never creates a false edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_vco_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_win_max  = 15'h7FFF >> (4'd15 - r_gate);
  assign w_win_last = (r_win == w_win_max);

  always_comb begin
    w_acc_next  = r_acc;
    w_pend_next = r_pend;
    if (w_edge) begin
      if (&r_acc) begin
        w_pend_next = 1'b1;
      end else begin
        w_acc_next = r_acc + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gate     <= '0;
      r_settle   <= '0;
      r_win      <= '0;
      r_acc      <= '0;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_vco_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_gate    <= i_gate_log2;
            r_acc     <= '0;
            r_pend    <= 1'b0;
            r_settle  <= '0;
            r_vco_rst <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_win   <= '0;
            r_state <= S_MEASURE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_MEASURE: begin
          // The final window cycle's edge is folded straight into the published result.
          r_acc  <= w_acc_next;
          r_pend <= w_pend_next;
          if (w_win_last) begin
            r_count    <= w_acc_next;
            r_overflow <= w_pend_next;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (i_continuous) begin
            r_gate  <= i_gate_log2;
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_win   <= '0;
            r_state <= S_MEASURE;
          end else begin
            r_vco_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_vco_rst <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  generate
    if (CNT_W >= 16) begin : g_wide
      assign w_cnt16 = r_count[15:0];
    end else begin : g_narrow
      assign w_cnt16 = {{(16-CNT_W){1'b0}}, r_count};
    end
  endgenerate

  assign o_vco_rst  = r_vco_rst;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_byte_out = i_rd_sel ? w_cnt16[15:8] : w_cnt16[7:0];

endmodule
